norm_round_pipe_mvp: RTL

Parametrised, pipelined normalise-round-pack stage for the div/sqrt unit. It takes the raw quotient or root mantissa, a biased exponent and a special-case class, and produces a packed IEEE-754 result plus fflags. It sits between the iteration datapath and the FPU result arbiter. Compared with the current combinational normaliser it adds:

- any single format chosen by parameters;
- 1–3 register stages with a valid/ready handshake and flush;
- RMM rounding;
- IEEE rounding-mode-dependent overflow saturation;
- a pass-through transaction tag.

---
 rtl/norm_round_pipe_mvp.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/norm_round_pipe_mvp.sv
// norm_round_pipe_mvp: pipelined normalise/round/pack stage producing an IEEE-754 result and fflags for the div/sqrt unit.
module norm_round_pipe_mvp #(
   parameter int EXP_BITS   = 11,
   parameter int MANT_BITS  = 52,
   parameter int NUM_STAGES = 2,
   parameter int TAG_W      = 4
) (
   input  logic                            Clk_CI,
   input  logic                            Rst_RBI,
   input  logic                            In_valid_SI,
   output logic                            In_ready_SO,
   input  logic                            Kill_SI,
   input  logic [MANT_BITS+4:0]            Mant_in_DI,
   input  logic [EXP_BITS+1:0]             Exp_in_DI,
   input  logic                            Sign_in_DI,
   input  logic [1:0]                      Class_in_DI,
   input  logic                            NV_in_SI,
   input  logic                            DZ_in_SI,
   input  logic [2:0]                      RM_SI,
   input  logic [TAG_W-1:0]                Tag_in_DI,
   output logic                            Out_valid_SO,
   input  logic                            Out_ready_SI,
   output logic [EXP_BITS+MANT_BITS:0]     Result_DO,
   output logic [4:0]                      Fflags_SO,
   output logic [TAG_W-1:0]                Tag_out_DO
);
   localparam int E  = EXP_BITS;
   localparam int M  = MANT_BITS;
   localparam int EW = E + 3;
   localparam int XW = 2 * M + 8;

   typedef struct packed {
      logic             sign;
      logic [1:0]       cls;
      logic             nv, dz;
      logic [2:0]       rm;
      logic [TAG_W-1:0] tag;
      logic [M:0]       sig;
      logic             g, s, sub;
      logic [E+1:0]     eb;
   } norm_t;

   typedef struct packed {
      logic             sign;
      logic [1:0]       cls;
      logic             nv, dz;
      logic [2:0]       rm;
      logic [TAG_W-1:0] tag;
      logic [M-1:0]     frac;
      logic [E-1:0]     eo;
      logic             ovf, uf, nx;
   } rnd_t;

   logic                en, v1, v2, sub, big, gs, up, maxf;
   logic [M+4:0]        mn;
   logic signed [EW-1:0] e, sh;
   logic [XW-1:0]       shx;
   logic [M+1:0]        sr;
   logic [E+1:0]        eo;
   logic [E+M:0]        res;
   logic [4:0]          fl;
   norm_t               na, nq;
   rnd_t                ra, rq;

   assign en          = ~Out_valid_SO | Out_ready_SI;
   assign In_ready_SO = en;

   // Subnormals keep the shifted-out bits below the significand so guard/sticky stay exact.
   always_comb begin
      mn        = Mant_in_DI[M+4] ? Mant_in_DI : Mant_in_DI << 1;
      e         = {Exp_in_DI[E+1], Exp_in_DI} - EW'(!Mant_in_DI[M+4]);
      sub       = e[EW-1] | ~|e;
      sh        = EW'(1) - e;
      big       = sub & (sh > EW'(M + 2));
      shx       = {mn, {(M+3){1'b0}}} >> (sub ? sh : EW'(0));
      na.sign   = Sign_in_DI;
      na.cls    = Class_in_DI;
      na.nv     = NV_in_SI;
      na.dz     = DZ_in_SI;
      na.rm     = RM_SI;
      na.tag    = Tag_in_DI;
      na.sig    = big ? '0 : shx[XW-1 -: M+1];
      na.g      = ~big & shx[M+6];
      na.s      = big ? |Mant_in_DI : |shx[M+5:0];
      na.sub    = sub;
      na.eb     = sub ? '0 : e[E+1:0];
   end

   generate
      if (NUM_STAGES >= 2) begin : g_s1
         always_ff @(posedge Clk_CI or negedge Rst_RBI)
            if (!Rst_RBI) begin
               v1 <= 1'b0;
               nq <= '0;
            end else if (Kill_SI) v1 <= 1'b0;
            else if (en) begin
               v1 <= In_valid_SI;
               nq <= na;
            end
      end else begin : g_s1c
         assign v1 = In_valid_SI;
         assign nq = na;
      end
   endgenerate

   // A carry out of a normal significand bumps the exponent; a subnormal reaching 1.0 gets exponent 1.
   always_comb begin
      gs      = nq.g | nq.s;
      up      = nq.rm == 3'd1 ? 1'b0 :
                nq.rm == 3'd2 ? gs & ~nq.sign :
                nq.rm == 3'd3 ? gs & nq.sign :
                nq.rm == 3'd4 ? nq.g : nq.g & (nq.s | nq.sig[0]);
      sr      = {1'b0, nq.sig} + (M+2)'(up);
      eo      = nq.eb + (E+2)'(nq.sub ? sr[M] : sr[M+1]);
      ra.sign = nq.sign;
      ra.cls  = nq.cls;
      ra.nv   = nq.nv;
      ra.dz   = nq.dz;
      ra.rm   = nq.rm;
      ra.tag  = nq.tag;
      ra.frac = sr[M+1] ? sr[M:1] : sr[M-1:0];
      ra.eo   = eo[E-1:0];
      ra.ovf  = eo >= {2'b00, {E{1'b1}}};
      ra.uf   = gs & nq.sub;
      ra.nx   = gs;
   end

   generate
      if (NUM_STAGES == 3) begin : g_s2
         always_ff @(posedge Clk_CI or negedge Rst_RBI)
            if (!Rst_RBI) begin
               v2 <= 1'b0;
               rq <= '0;
            end else if (Kill_SI) v2 <= 1'b0;
            else if (en) begin
               v2 <= v1;
               rq <= ra;
            end
      end else begin : g_s2c
         assign v2 = v1;
         assign rq = ra;
      end
   endgenerate

   always_comb begin
      maxf = rq.rm == 3'd1 | (rq.rm == 3'd2 & rq.sign) | (rq.rm == 3'd3 & ~rq.sign);
      res  = rq.cls == 2'b01 ? {rq.sign, {(E+M){1'b0}}} :
             rq.cls == 2'b10 ? {rq.sign, {E{1'b1}}, {M{1'b0}}} :
             rq.cls == 2'b11 ? {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}} :
             !rq.ovf         ? {rq.sign, rq.eo, rq.frac} :
             maxf            ? {rq.sign, {(E-1){1'b1}}, 1'b0, {M{1'b1}}} :
                               {rq.sign, {E{1'b1}}, {M{1'b0}}};
      fl   = rq.cls != 2'b00 ? {rq.nv, rq.dz, 3'b000} :
                               {rq.nv, rq.dz, rq.ovf, rq.uf, rq.nx | rq.ovf};
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI)
      if (!Rst_RBI) begin
         Out_valid_SO <= 1'b0;
         Result_DO    <= '0;
         Fflags_SO    <= '0;
         Tag_out_DO   <= '0;
      end else if (Kill_SI) Out_valid_SO <= 1'b0;
      else if (en) begin
         Out_valid_SO <= v2;
         Result_DO    <= res;
         Fflags_SO    <= fl;
         Tag_out_DO   <= rq.tag;
      end
endmodule
